sec_to_hms_decoder: RTL

//  Decodes a 17-bit seconds-of-day value (0..86399) from the time-of-day counter into BCD HH:MM:SS.

---
 rtl/sec_to_hms_decoder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sec_to_hms_decoder.sv
// rtl/sec_to_hms_decoder.sv - seconds-of-day to BCD HH:MM:SS by iterative subtraction
// Optional 6-digit seven-segment scan driver enabled by defining SEVSEG_EN.
module sec_to_hms_decoder
`ifdef SEVSEG_EN
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] sec_in,
  input  logic        load,
  output logic        ready,
  output logic        valid,
  output logic [7:0]  hh_bcd,
  output logic [7:0]  mm_bcd,
  output logic [7:0]  ss_bcd,
  output logic        err
`ifdef SEVSEG_EN
  ,
  output logic [6:0]  seg,
  output logic [5:0]  an
`endif
);

  typedef enum logic [2:0] {IDLE, HRS, MIN, SEC, DONE} state_t;

  state_t      state;
  logic [16:0] rem;
  logic [3:0]  h_t, h_u, m_t, m_u, s_t, s_u;

  // Conversion FSM: one subtraction per clock, results and valid registered on leaving DONE.
  // Out-of-range inputs enter SEC with rem cleared, so they finish through the same
  // DONE path with all digits zero two clocks after the load edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ready  <= 1'b1;
      valid  <= 1'b0;
      rem    <= '0;
      h_t    <= '0;
      h_u    <= '0;
      m_t    <= '0;
      m_u    <= '0;
      s_t    <= '0;
      s_u    <= '0;
      hh_bcd <= 8'h00;
      mm_bcd <= 8'h00;
      ss_bcd <= 8'h00;
      err    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            h_t   <= '0;
            h_u   <= '0;
            m_t   <= '0;
            m_u   <= '0;
            s_t   <= '0;
            s_u   <= '0;
            ready <= 1'b0;
            err   <= (sec_in >= 17'd86400);
            if (sec_in >= 17'd86400) begin
              rem   <= '0;
              state <= SEC;
            end else begin
              rem   <= sec_in;
              state <= HRS;
            end
          end
        end
        HRS: begin
          if (rem >= 17'd3600) begin
            rem <= rem - 17'd3600;
            if (h_u == 4'd9) begin
              h_u <= 4'd0;
              h_t <= h_t + 4'd1;
            end else begin
              h_u <= h_u + 4'd1;
            end
          end else begin
            state <= MIN;
          end
        end
        MIN: begin
          if (rem >= 17'd60) begin
            rem <= rem - 17'd60;
            if (m_u == 4'd9) begin
              m_u <= 4'd0;
              m_t <= m_t + 4'd1;
            end else begin
              m_u <= m_u + 4'd1;
            end
          end else begin
            state <= SEC;
          end
        end
        SEC: begin
          if (rem >= 17'd10) begin
            rem <= rem - 17'd10;
            s_t <= s_t + 4'd1;
          end else begin
            s_u   <= rem[3:0];
            state <= DONE;
          end
        end
        DONE: begin
          hh_bcd <= {h_t, h_u};
          mm_bcd <= {m_t, m_u};
          ss_bcd <= {s_t, s_u};
          valid  <= 1'b1;
          ready  <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef SEVSEG_EN
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc;
  logic [2:0]    sel;
  logic [3:0]    nib;
  logic [5:0]    an_oh;
  logic [6:0]    seg_raw;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Prescaler and round-robin digit select; digit 0 is hours tens on an[5].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      sel   <= 3'd0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      sel   <= (sel == 3'd5) ? 3'd0 : sel + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Pick the digit nibble for the current slot and decode it; err shows a dash everywhere.
  always_comb begin
    nib = 4'h0;
    case (sel)
      3'd0: nib = hh_bcd[7:4];
      3'd1: nib = hh_bcd[3:0];
      3'd2: nib = mm_bcd[7:4];
      3'd3: nib = mm_bcd[3:0];
      3'd4: nib = ss_bcd[7:4];
      3'd5: nib = ss_bcd[3:0];
      default: nib = 4'h0;
    endcase
    an_oh   = 6'b100000 >> sel;
    seg_raw = err ? 7'h40 : hex7(nib);
  end

  // Registered drive with polarity applied; reset leaves everything dark.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
      an  <= SEG_ACTIVE_LOW ? 6'h3F : 6'h00;
    end else begin
      seg <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      an  <= SEG_ACTIVE_LOW ? ~an_oh : an_oh;
    end
  end
`endif

endmodule
